wr_port_arbiter: RTL

- Round-robin arbiter and sequencer that shares the single register-bank write port between three requesters (A, B, C).
- Drives the 2-bit select of the downstream 3:1 address mux. Select codes are 00=A, 01=B and 10=C; 11 is never produced.
- Also produces the registered write strobe, address and data for the bank.
- Supports single writes and locked bursts, with a bounded burst length and optional protection of address 0.

---
 rtl/wr_port_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
// Shares the single register-bank write port between requesters A, B and C.
// Round-robin selection between A, B and C, with locked bursts of at most
// MAX_BURST writes. Every grant is followed by one idle GAP cycle.
// All outputs are registered. mux_sel only ever carries 00, 01 or 10.
// busy is high on the follow-on writes of a burst, i.e. the cycles where the
// port is held by an owner without a fresh arbitration.
module wr_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [4:0]        addr_a,
  input  logic [4:0]        addr_b,
  input  logic [4:0]        addr_c,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] data_c,
  output logic [2:0]        gnt,
  output logic [1:0]        mux_sel,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  // Bursts are only possible when more than one write per grant is allowed.
  localparam bit         BURST_EN = (MAX_BURST > 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t              state_r;
  logic [1:0]          ptr_r;
  logic [1:0]          owner_r;
  logic [3:0]          cnt_r;
  logic [2:0]          gnt_r;
  logic [1:0]          mux_sel_r;
  logic                wr_en_r;
  logic [4:0]          wr_addr_r;
  logic [DATA_W-1:0]   wr_data_r;
  logic                busy_r;

  logic [1:0]          pick_s;
  logic [1:0]          src_s;
  logic [4:0]          src_addr_s;
  logic [DATA_W-1:0]   src_data_s;
  logic                burst_cont_s;
  logic [3:0]          cnt_next_s;

  // Successor of a requester index in the fixed ring A -> B -> C -> A.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // One-hot grant vector for a requester index; index 3 maps to no grant.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // First requesting index, searching from ptr and wrapping C -> A.
  // Only meaningful when r is nonzero; otherwise returns the last candidate.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] win;
    c0 = ptr;
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    if (r[c0]) begin
      win = c0;
    end else if (r[c1]) begin
      win = c1;
    end else begin
      win = c2;
    end
    return win;
  endfunction

  // Write strobe qualifier: address 0 is write-protected when enabled.
  function automatic logic wr_allow(input logic [4:0] a);
    logic ok;
    if (ZERO_PROTECT) begin
      ok = (a != 5'd0);
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // Arbitration decision and address/data source selection for this edge.
  always_comb begin
    pick_s       = rr_pick(req, ptr_r);
    src_s        = (state_r == BURST) ? owner_r : pick_s;
    burst_cont_s = req[owner_r] & lock[owner_r];
    cnt_next_s   = cnt_r + 4'd1;
    case (src_s)
      2'd0: begin
        src_addr_s = addr_a;
        src_data_s = data_a;
      end
      2'd1: begin
        src_addr_s = addr_b;
        src_data_s = data_b;
      end
      2'd2: begin
        src_addr_s = addr_c;
        src_data_s = data_c;
      end
      default: begin
        src_addr_s = 5'd0;
        src_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Sequencer FSM with registered grant, mux select and write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      owner_r   <= 2'd0;
      cnt_r     <= 4'd0;
      gnt_r     <= 3'b000;
      mux_sel_r <= 2'b00;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are re-asserted only when a write issues.
      gnt_r   <= 3'b000;
      wr_en_r <= 1'b0;
      busy_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req != 3'b000) begin
            gnt_r     <= onehot(pick_s);
            mux_sel_r <= pick_s;
            wr_addr_r <= src_addr_s;
            wr_data_r <= src_data_s;
            wr_en_r   <= wr_allow(src_addr_s);
            if (BURST_EN && lock[pick_s]) begin
              state_r <= BURST;
              owner_r <= pick_s;
              cnt_r   <= 4'd1;
            end else begin
              state_r <= GAP;
              ptr_r   <= next_idx(pick_s);
              cnt_r   <= 4'd0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          if (burst_cont_s) begin
            gnt_r     <= onehot(owner_r);
            mux_sel_r <= owner_r;
            wr_addr_r <= src_addr_s;
            wr_data_r <= src_data_s;
            wr_en_r   <= wr_allow(src_addr_s);
            busy_r    <= 1'b1;
            if (cnt_next_s >= MAX_CNT) begin
              state_r <= GAP;
              ptr_r   <= next_idx(owner_r);
              cnt_r   <= 4'd0;
            end else begin
              cnt_r   <= cnt_next_s;
            end
          end else begin
            // Owner released the burst early: the grant ends here.
            state_r <= GAP;
            ptr_r   <= next_idx(owner_r);
            cnt_r   <= 4'd0;
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign mux_sel = mux_sel_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;

endmodule
